// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
//
// Instruction prefetch queue sitting between the fetch stage and the decode
// pipeline register. Fetch pushes {instruction, PC+4} pairs while there is
// room, decode pops one entry per cycle unless stalled, and a branch/jump
// redirect (flush) discards every queued entry so no wrong-path instruction
// reaches decode.
//
// Ports:
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset (clears pointers and count)
//   in_valid       fetch presents a valid entry
//   in_instr       fetched instruction
//   in_pc_plus_4   PC+4 of that instruction
//   in_ready       queue accepts a push this cycle (count != DEPTH)
//   flush          redirect; empties the queue at the next edge
//   out_ready      decode register captures this cycle (~StallD)
//   out_valid      head entry is valid (count != 0)
//   out_instr      head instruction, 0 (nop) when empty
//   out_pc_plus_4  head PC+4, 0 when empty
//   count          occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module fetch_queue #(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic [31:0]   in_instr,
    input  logic [31:0]   in_pc_plus_4,
    output logic          in_ready,
    input  logic          flush,
    input  logic          out_ready,
    output logic          out_valid,
    output logic [31:0]   out_instr,
    output logic [31:0]   out_pc_plus_4,
    output logic [CW-1:0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [63:0]   mem_r [DEPTH];
    logic [AW-1:0] wp_r;
    logic [AW-1:0] rp_r;
    logic [CW-1:0] count_r;
    logic          push_s;
    logic          pop_s;
    logic [63:0]   head_s;

    // Handshake decode; ready and valid come from the registered count only,
    // so out_ready never reaches in_ready combinationally.
    always_comb begin
        in_ready  = (count_r != CW'(DEPTH));
        out_valid = (count_r != CW'(0));
        push_s    = in_valid && in_ready && !flush;
        pop_s     = out_valid && out_ready && !flush;
    end

    // Head read; an empty queue presents a zero (nop) bubble to decode.
    always_comb begin
        head_s = 64'h0000_0000_0000_0000;
        if (out_valid) begin
            head_s = mem_r[rp_r];
        end else begin
            head_s = 64'h0000_0000_0000_0000;
        end
        out_instr     = head_s[63:32];
        out_pc_plus_4 = head_s[31:0];
    end

    assign count = count_r;

    // Storage write; contents are intentionally left untouched by reset and
    // flush since the pointers alone decide what is visible.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wp_r] <= {in_instr, in_pc_plus_4};
        end
    end

    // Write pointer; wraps naturally modulo DEPTH (DEPTH is a power of two).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp_r <= AW'(0);
        end else if (flush) begin
            wp_r <= AW'(0);
        end else if (push_s) begin
            wp_r <= wp_r + AW'(1);
        end
    end

    // Read pointer; held while decode stalls so the head stays stable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rp_r <= AW'(0);
        end else if (flush) begin
            rp_r <= AW'(0);
        end else if (pop_s) begin
            rp_r <= rp_r + AW'(1);
        end
    end

    // Occupancy count; flush wins over any push/pop in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= CW'(0);
        end else if (flush) begin
            count_r <= CW'(0);
        end else begin
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// -----------------------------------------------------------------------------
// tb_fetch_queue
//
// Directed table-driven bench for fetch_queue (DEPTH=4). Each table row gives
// the inputs driven during one cycle and the outputs expected during that
// same cycle (i.e. the state left by the previous edges). A hand-written
// sequence covers the asynchronous reset in the middle of a cycle.
// -----------------------------------------------------------------------------
module tb_fetch_queue;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic [31:0]   in_instr;
    logic [31:0]   in_pc_plus_4;
    logic          in_ready;
    logic          flush;
    logic          out_ready;
    logic          out_valid;
    logic [31:0]   out_instr;
    logic [31:0]   out_pc_plus_4;
    logic [CW-1:0] count;

    int n_pass;
    int n_total;

    fetch_queue #(.DEPTH(DEPTH), .CW(CW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_instr     (in_instr),
        .in_pc_plus_4 (in_pc_plus_4),
        .in_ready     (in_ready),
        .flush        (flush),
        .out_ready    (out_ready),
        .out_valid    (out_valid),
        .out_instr    (out_instr),
        .out_pc_plus_4(out_pc_plus_4),
        .count        (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        iv;
        logic [31:0] instr;
        logic [31:0] pc;
        logic        ordy;
        logic        fl;
        int          e_cnt;
        logic        e_val;
        logic        e_rdy;
        logic [31:0] e_instr;
        logic [31:0] e_pc;
    } vec_t;

    vec_t vecs[22];

    function automatic vec_t mk(input logic iv, input logic [31:0] instr,
                                input logic [31:0] pc, input logic ordy,
                                input logic fl, input int e_cnt,
                                input logic e_val, input logic e_rdy,
                                input logic [31:0] e_instr,
                                input logic [31:0] e_pc);
        vec_t v;
        v.iv = iv; v.instr = instr; v.pc = pc; v.ordy = ordy; v.fl = fl;
        v.e_cnt = e_cnt; v.e_val = e_val; v.e_rdy = e_rdy;
        v.e_instr = e_instr; v.e_pc = e_pc;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag, input int e_cnt,
                             input logic e_val, input logic e_rdy,
                             input logic [31:0] e_instr,
                             input logic [31:0] e_pc);
        check({tag, ".count"},     32'(count),         32'(e_cnt));
        check({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, e_val});
        check({tag, ".in_ready"},  {31'd0, in_ready},  {31'd0, e_rdy});
        check({tag, ".out_instr"}, out_instr,          e_instr);
        check({tag, ".out_pc"},    out_pc_plus_4,      e_pc);
    endtask

    localparam logic [31:0] I_A = 32'h2008_0001;
    localparam logic [31:0] I_B = 32'h2009_0002;
    localparam logic [31:0] I_C = 32'h200A_0003;
    localparam logic [31:0] I_D = 32'h200B_0004;
    localparam logic [31:0] I_E = 32'h200C_0005;
    localparam logic [31:0] I_F = 32'h2010_0006;
    localparam logic [31:0] I_G = 32'h2011_0007;
    localparam logic [31:0] I_H = 32'h2012_0008;
    localparam logic [31:0] I_I = 32'h2013_0009;
    localparam logic [31:0] I_J = 32'h2014_000A;
    localparam logic [31:0] I_K = 32'h2015_000B;
    localparam logic [31:0] I_L = 32'h2016_000C;
    localparam logic [31:0] I_M = 32'h2017_000D;
    localparam logic [31:0] BAD = 32'hDEAD_BEEF;
    localparam logic [31:0] Z   = 32'h0000_0000;

    initial begin
        n_pass  = 0;
        n_total = 0;

        // Reset / empty, fill with stall, refused fifth push, drain across
        // the wp wrap, simultaneous push/pop at count=2, flush priority.
        vecs[0]  = mk(1'b0, Z,   Z,           1'b0, 1'b0, 0, 1'b0, 1'b1, Z,   Z);
        vecs[1]  = mk(1'b1, I_A, 32'd4,       1'b0, 1'b0, 0, 1'b0, 1'b1, Z,   Z);
        vecs[2]  = mk(1'b1, I_B, 32'd8,       1'b0, 1'b0, 1, 1'b1, 1'b1, I_A, 32'd4);
        vecs[3]  = mk(1'b1, I_C, 32'd12,      1'b0, 1'b0, 2, 1'b1, 1'b1, I_A, 32'd4);
        vecs[4]  = mk(1'b1, I_D, 32'd16,      1'b0, 1'b0, 3, 1'b1, 1'b1, I_A, 32'd4);
        vecs[5]  = mk(1'b1, I_E, 32'd20,      1'b0, 1'b0, 4, 1'b1, 1'b0, I_A, 32'd4);
        vecs[6]  = mk(1'b1, I_E, 32'd20,      1'b1, 1'b0, 4, 1'b1, 1'b0, I_A, 32'd4);
        vecs[7]  = mk(1'b1, I_E, 32'd20,      1'b1, 1'b0, 3, 1'b1, 1'b1, I_B, 32'd8);
        vecs[8]  = mk(1'b0, Z,   Z,           1'b1, 1'b0, 3, 1'b1, 1'b1, I_C, 32'd12);
        vecs[9]  = mk(1'b0, Z,   Z,           1'b1, 1'b0, 2, 1'b1, 1'b1, I_D, 32'd16);
        vecs[10] = mk(1'b0, Z,   Z,           1'b1, 1'b0, 1, 1'b1, 1'b1, I_E, 32'd20);
        vecs[11] = mk(1'b1, I_F, 32'd24,      1'b0, 1'b0, 0, 1'b0, 1'b1, Z,   Z);
        vecs[12] = mk(1'b1, I_G, 32'd28,      1'b0, 1'b0, 1, 1'b1, 1'b1, I_F, 32'd24);
        vecs[13] = mk(1'b1, I_H, 32'd32,      1'b1, 1'b0, 2, 1'b1, 1'b1, I_F, 32'd24);
        vecs[14] = mk(1'b1, I_I, 32'd36,      1'b1, 1'b0, 2, 1'b1, 1'b1, I_G, 32'd28);
        vecs[15] = mk(1'b1, I_J, 32'd40,      1'b1, 1'b0, 2, 1'b1, 1'b1, I_H, 32'd32);
        vecs[16] = mk(1'b1, I_K, 32'd44,      1'b0, 1'b0, 2, 1'b1, 1'b1, I_I, 32'd36);
        vecs[17] = mk(1'b1, BAD, 32'h0000_0BAD, 1'b1, 1'b1, 3, 1'b1, 1'b1, I_I, 32'd36);
        vecs[18] = mk(1'b0, Z,   Z,           1'b1, 1'b0, 0, 1'b0, 1'b1, Z,   Z);
        vecs[19] = mk(1'b1, I_L, 32'd48,      1'b0, 1'b0, 0, 1'b0, 1'b1, Z,   Z);
        vecs[20] = mk(1'b1, I_M, 32'd52,      1'b0, 1'b0, 1, 1'b1, 1'b1, I_L, 32'd48);
        vecs[21] = mk(1'b0, Z,   Z,           1'b0, 1'b0, 2, 1'b1, 1'b1, I_L, 32'd48);

        rst_n        = 1'b0;
        in_valid     = 1'b0;
        in_instr     = 32'h0000_0000;
        in_pc_plus_4 = 32'h0000_0000;
        flush        = 1'b0;
        out_ready    = 1'b0;

        // Outputs held at reset values while rst_n is low across edges.
        repeat (2) @(negedge clk);
        check_all("reset", 0, 1'b0, 1'b1, Z, Z);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 22; i++) begin
            in_valid     = vecs[i].iv;
            in_instr     = vecs[i].instr;
            in_pc_plus_4 = vecs[i].pc;
            out_ready    = vecs[i].ordy;
            flush        = vecs[i].fl;
            #1;
            check_all($sformatf("vec%0d", i), vecs[i].e_cnt, vecs[i].e_val,
                      vecs[i].e_rdy, vecs[i].e_instr, vecs[i].e_pc);
            if (out_instr === BAD) begin
                check($sformatf("vec%0d.no_flushed", i), out_instr, Z);
            end
            @(negedge clk);
        end

        // Asynchronous reset between edges with count=2.
        in_valid  = 1'b0;
        out_ready = 1'b0;
        flush     = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_all("async_rst", 0, 1'b0, 1'b1, Z, Z);
        @(negedge clk);
        rst_n        = 1'b1;
        in_valid     = 1'b1;
        in_instr     = 32'h0000_0020;
        in_pc_plus_4 = 32'h0000_0104;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check_all("post_rst", 1, 1'b1, 1'b1, 32'h0000_0020, 32'h0000_0104);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
